// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU command encodings, command limits and
// protocol-monitor pairing states.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD, SUB, ADD_CIN, SUB_CIN,
        INC_A, DEC_A, INC_B, DEC_B,
        CMP, INC_MUL, SH_MUL
    } arith_cmd_e;

    typedef enum logic [3:0] {
        AND, NAND, OR, NOR, XOR, XNOR,
        NOT_A, NOT_B,
        SHR1_A, SHL1_A, SHR1_B, SHL1_B,
        ROL_A_B, ROR_A_B
    } logic_cmd_e;

    localparam int ARITH_MAX_CMD = 10;
    localparam int LOGIC_MAX_CMD = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_B = 2'b01,
        WAIT_A = 2'b10
    } pair_state_e;

endpackage

// File: rtl/alu_sat_counter.sv
// alu_sat_counter: saturating event counter, clr has priority.
// Ports: clk, rst (sync, active-low), clr, inc, cnt.
module alu_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_protocol_monitor.sv
// alu_protocol_monitor: watches ALU pins for pairing timeouts,
// output changes while ce is low and illegal commands.
// Ports: clk, rst (sync, active-low), ce, mode, inp_valid, cmd,
// res, err/cout/oflow/g/l/e, clr -> viol_* pulses, *_cnt, pend.
module alu_protocol_monitor
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CMD_WIDTH   = 4,
    parameter int RES_WIDTH   = 2 * DATA_WIDTH,
    parameter int WAIT_CYCLES = 16,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 mode,
    input  logic [1:0]           inp_valid,
    input  logic [CMD_WIDTH-1:0] cmd,
    input  logic [RES_WIDTH-1:0] res,
    input  logic                 err,
    input  logic                 cout,
    input  logic                 oflow,
    input  logic                 g,
    input  logic                 l,
    input  logic                 e,
    input  logic                 clr,
    output logic                 viol_timeout,
    output logic                 viol_stable,
    output logic                 viol_cmd,
    output logic [CNT_WIDTH-1:0] timeout_cnt,
    output logic [CNT_WIDTH-1:0] stable_cnt,
    output logic [CNT_WIDTH-1:0] cmd_cnt,
    output logic [1:0]           pend
);

    localparam int BUS_W = RES_WIDTH + 6;
    localparam logic [7:0] WIN = 8'(WAIT_CYCLES);

    pair_state_e      state;
    logic [7:0]       wait_cnt;
    logic [BUS_W-1:0] bus;
    logic [BUS_W-1:0] snap;
    logic             snap_ok;
    logic             ce_d;
    logic             same_op;
    logic             partner;
    logic             hit_timeout;
    logic             hit_stable;
    logic             hit_cmd;
    logic [31:0]      cmd_ext;

    assign bus     = {res, err, cout, oflow, g, l, e};
    assign cmd_ext = 32'(cmd);
    assign pend    = state;

    always_comb begin
        same_op = 1'b0;
        partner = 1'b0;
        case (state)
            WAIT_B: begin
                same_op = (inp_valid == 2'b01);
                partner = inp_valid[1];
            end
            WAIT_A: begin
                same_op = (inp_valid == 2'b10);
                partner = inp_valid[0];
            end
            default: ;
        endcase
    end

    // Window expiry: wait_cnt reaches WAIT_CYCLES on the edge after
    // the last accepted partner slot; re-presenting the same
    // operand restarts the window instead.
    assign hit_timeout = ce && (state != IDLE) && !same_op
                         && (wait_cnt == WIN);

    assign hit_stable = snap_ok && !ce_d && (bus != snap);

    assign hit_cmd = ce && (inp_valid != 2'b00) &&
                     (mode ? (cmd_ext > 32'(ARITH_MAX_CMD))
                           : (cmd_ext > 32'(LOGIC_MAX_CMD)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (inp_valid == 2'b01) begin
                        state    <= WAIT_B;
                        wait_cnt <= 8'd1;
                    end else if (inp_valid == 2'b10) begin
                        state    <= WAIT_A;
                        wait_cnt <= 8'd1;
                    end
                end
                default: begin
                    if (same_op) begin
                        wait_cnt <= 8'd1;
                    end else if (hit_timeout || partner) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            viol_timeout <= 1'b0;
            viol_stable  <= 1'b0;
            viol_cmd     <= 1'b0;
            ce_d         <= 1'b0;
            snap_ok      <= 1'b0;
            snap         <= '0;
        end else begin
            viol_timeout <= hit_timeout;
            viol_stable  <= hit_stable;
            viol_cmd     <= hit_cmd;
            ce_d         <= ce;
            snap_ok      <= 1'b1;
            snap         <= bus;
        end
    end

    alu_sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout_cnt (
        .clk(clk), .rst(rst), .clr(clr),
        .inc(hit_timeout), .cnt(timeout_cnt)
    );

    alu_sat_counter #(.WIDTH(CNT_WIDTH)) u_stable_cnt (
        .clk(clk), .rst(rst), .clr(clr),
        .inc(hit_stable), .cnt(stable_cnt)
    );

    alu_sat_counter #(.WIDTH(CNT_WIDTH)) u_cmd_cnt (
        .clk(clk), .rst(rst), .clr(clr),
        .inc(hit_cmd), .cnt(cmd_cnt)
    );

endmodule
